// File: rtl/interrupt_ack_control.sv
// rtl/interrupt_ack_control.sv - interrupt resolution, two-pulse INTA sequencing, vector and EOI generation
//
// Purpose: picks the highest-priority unmasked request that outranks the level in
// service, raises INT, walks the two-pulse INTA# handshake, loads the acknowledged
// level into the in-service stage, drives the vector byte and issues EOI pulses.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   interrupt_acknowledge_n       INTA#, synchronised, active-low
//   interrupt_request_register    pending requests, bit n = IRn
//   interrupt_mask                1 = level masked
//   highest_level_in_service      one-hot level currently in service, 0 = none
//   priority_rotate               lowest-priority level
//   vector_base                   upper five vector bits
//   auto_eoi                      issue EOI automatically at end of second INTA
//   eoi_command/_specific/_level  EOI command strobe and its operands
//   interrupt_to_cpu              INT pin
//   latch_in_service              one-cycle load strobe for the in-service stage
//   interrupt                     one-hot acknowledged level, held
//   clear_interrupt_request       one-cycle one-hot IRR clear
//   end_of_interrupt              one-cycle one-hot ISR clear
//   vector_out, vector_out_enable vector byte and its bus enable

module interrupt_ack_control #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] highest_level_in_service,
  input  logic [2:0] priority_rotate,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi_command,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       interrupt_to_cpu,
  output logic       latch_in_service,
  output logic [7:0] interrupt,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] end_of_interrupt,
  output logic [7:0] vector_out,
  output logic       vector_out_enable
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state;
  logic       inta_q;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] level;
  logic       ack_valid;

  logic [7:0] candidates;
  logic       win_found;
  logic [2:0] win_level;
  logic [2:0] win_rank;
  logic       isr_found;
  logic [2:0] isr_rank;
  logic       win_valid;
  logic [2:0] scan_level;
  logic [7:0] cmd_eoi;

  function automatic logic [7:0] one_hot(input logic [2:0] l);
    return 8'(1) << l;
  endfunction

  assign inta_fall = inta_q & ~interrupt_acknowledge_n;
  assign inta_rise = ~inta_q & interrupt_acknowledge_n;

  // Scan from rank 0 upward; the level holding rank r is rotate + 1 + r (mod 8).
  always_comb begin
    candidates = interrupt_request_register & ~interrupt_mask;
    win_found  = 1'b0;
    win_level  = 3'd0;
    win_rank   = 3'd7;
    isr_found  = 1'b0;
    isr_rank   = 3'd7;
    scan_level = 3'd0;
    for (int r = 0; r < 8; r++) begin
      scan_level = 3'(r) + priority_rotate + 3'd1;
      if (!win_found && candidates[scan_level]) begin
        win_found = 1'b1;
        win_level = scan_level;
        win_rank  = 3'(r);
      end
      if (!isr_found && highest_level_in_service[scan_level]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(r);
      end
    end
    win_valid = win_found && (!isr_found || (win_rank < isr_rank));
  end

  always_comb begin
    cmd_eoi = 8'd0;
    if (eoi_command)
      cmd_eoi = eoi_specific ? one_hot(eoi_level) : highest_level_in_service;
  end

  always_ff @(posedge clock) begin
    // The edge detector keeps tracking the pin through reset so a level held
    // low during reset is not mistaken for a fresh falling edge afterwards.
    inta_q <= interrupt_acknowledge_n;
    if (reset) begin
      state                   <= IDLE;
      level                   <= 3'd0;
      ack_valid               <= 1'b0;
      interrupt_to_cpu        <= 1'b0;
      latch_in_service        <= 1'b0;
      interrupt               <= 8'd0;
      clear_interrupt_request <= 8'd0;
      end_of_interrupt        <= 8'd0;
      vector_out              <= 8'd0;
      vector_out_enable       <= 1'b0;
    end else begin
      latch_in_service        <= 1'b0;
      clear_interrupt_request <= 8'd0;
      end_of_interrupt        <= cmd_eoi;
      case (state)
        IDLE: begin
          if (inta_fall) begin
            state            <= ACK1;
            interrupt_to_cpu <= 1'b0;
            if (win_valid) begin
              level                   <= win_level;
              ack_valid               <= 1'b1;
              latch_in_service        <= 1'b1;
              clear_interrupt_request <= one_hot(win_level);
              interrupt               <= one_hot(win_level);
            end else begin
              // Request vanished before the first INTA: report the spurious level.
              level     <= SPURIOUS_LEVEL;
              ack_valid <= 1'b0;
            end
          end else begin
            interrupt_to_cpu <= win_valid;
          end
        end
        ACK1: begin
          if (inta_rise) state <= WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            state             <= ACK2;
            vector_out        <= {vector_base, level};
            vector_out_enable <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state             <= IDLE;
            vector_out_enable <= 1'b0;
            if (auto_eoi && ack_valid)
              end_of_interrupt <= cmd_eoi | one_hot(level);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb/tb_interrupt_ack_control.sv - directed and randomized checks of interrupt_ack_control
//
// Purpose: drives INTA# handshakes against a priority model and checks INT, latch,
// clear, interrupt, vector and EOI outputs.
// Ports: none (top-level bench).

module tb_interrupt_ack_control;

  logic       clock = 1'b0;
  logic       rst;
  logic       inta_n;
  logic [7:0] irr;
  logic [7:0] mask;
  logic [7:0] isr;
  logic [2:0] rot;
  logic [4:0] vbase;
  logic       aeoi;
  logic       eoi_cmd;
  logic       eoi_spec;
  logic [2:0] eoi_lvl;

  logic       int_cpu;
  logic       latch;
  logic [7:0] intr;
  logic [7:0] clr;
  logic [7:0] eoi;
  logic [7:0] vec_out;
  logic       vec_en;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_interrupt = 8'd0;

  always #5 clock = ~clock;

  interrupt_ack_control dut (
    .clock                      (clock),
    .reset                      (rst),
    .interrupt_acknowledge_n    (inta_n),
    .interrupt_request_register (irr),
    .interrupt_mask             (mask),
    .highest_level_in_service   (isr),
    .priority_rotate            (rot),
    .vector_base                (vbase),
    .auto_eoi                   (aeoi),
    .eoi_command                (eoi_cmd),
    .eoi_specific               (eoi_spec),
    .eoi_level                  (eoi_lvl),
    .interrupt_to_cpu           (int_cpu),
    .latch_in_service           (latch),
    .interrupt                  (intr),
    .clear_interrupt_request    (clr),
    .end_of_interrupt           (eoi),
    .vector_out                 (vec_out),
    .vector_out_enable          (vec_en)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] oh(input int n);
    logic [7:0] v;
    v = 8'd0;
    v[n] = 1'b1;
    return v;
  endfunction

  // Winning level, or -1 when nothing may interrupt the current service level.
  function automatic int model_winner(input logic [7:0] r, input logic [7:0] m,
                                      input logic [7:0] s, input logic [2:0] rt);
    int best = -1;
    int best_rank = 8;
    int isr_rank = 8;
    for (int n = 0; n < 8; n++) begin
      int rk;
      rk = (n - int'(rt) - 1 + 16) % 8;
      if (r[n] && !m[n] && rk < best_rank) begin
        best_rank = rk;
        best = n;
      end
      if (s[n] && rk < isr_rank) isr_rank = rk;
    end
    if (best >= 0 && best_rank < isr_rank) return best;
    return -1;
  endfunction

  task automatic do_ack(input string tag, input bit drop_req, input bit eoi_at_rise);
    int lvl;
    logic [7:0] exp_eoi;
    logic [7:0] vec;
    lvl = model_winner(irr, mask, isr, rot);
    step();
    chk({tag, ".int"}, 32'(int_cpu), 32'(lvl >= 0));
    if (drop_req) begin
      irr = 8'h00;
      lvl = model_winner(irr, mask, isr, rot);
    end
    inta_n = 1'b0;
    step();
    chk({tag, ".int_off"}, 32'(int_cpu), 32'd0);
    chk({tag, ".latch"}, 32'(latch), 32'(lvl >= 0));
    chk({tag, ".clear"}, 32'(clr), (lvl >= 0) ? 32'(oh(lvl)) : 32'd0);
    if (lvl >= 0) exp_interrupt = oh(lvl);
    chk({tag, ".interrupt"}, 32'(intr), 32'(exp_interrupt));
    step();
    chk({tag, ".latch_end"}, 32'(latch), 32'd0);
    chk({tag, ".clear_end"}, 32'(clr), 32'd0);
    chk({tag, ".interrupt_hold"}, 32'(intr), 32'(exp_interrupt));
    inta_n = 1'b1;
    step();
    chk({tag, ".en_wait2"}, 32'(vec_en), 32'd0);
    inta_n = 1'b0;
    step();
    vec = {vbase, (lvl >= 0) ? 3'(lvl) : 3'd7};
    chk({tag, ".en_ack2"}, 32'(vec_en), 32'd1);
    chk({tag, ".vector"}, 32'(vec_out), 32'(vec));
    inta_n = 1'b1;
    exp_eoi = (aeoi && lvl >= 0) ? oh(lvl) : 8'd0;
    if (eoi_at_rise) begin
      eoi_cmd  = 1'b1;
      eoi_spec = 1'b1;
      eoi_lvl  = 3'd5;
      exp_eoi  = exp_eoi | 8'h20;
    end
    step();
    eoi_cmd = 1'b0;
    chk({tag, ".en_off"}, 32'(vec_en), 32'd0);
    chk({tag, ".eoi"}, 32'(eoi), 32'(exp_eoi));
    chk({tag, ".vector_hold"}, 32'(vec_out), 32'(vec));
    step();
    chk({tag, ".eoi_end"}, 32'(eoi), 32'd0);
  endtask

  initial begin
    rst = 1'b1; inta_n = 1'b1; irr = 8'd0; mask = 8'd0; isr = 8'd0; rot = 3'd7;
    vbase = 5'd0; aeoi = 1'b0; eoi_cmd = 1'b0; eoi_spec = 1'b0; eoi_lvl = 3'd0;
    step();
    step();
    chk("reset.int", 32'(int_cpu), 32'd0);
    chk("reset.latch", 32'(latch), 32'd0);
    chk("reset.interrupt", 32'(intr), 32'd0);
    chk("reset.clear", 32'(clr), 32'd0);
    chk("reset.eoi", 32'(eoi), 32'd0);
    chk("reset.vector", 32'(vec_out), 32'd0);
    chk("reset.en", 32'(vec_en), 32'd0);
    rst = 1'b0;

    // IR3 with vector base 0x11 -> vector 0x8B
    irr = 8'h08; vbase = 5'h11;
    do_ack("ir3", 1'b0, 1'b0);
    irr = 8'h00;

    // Rotation: IR7 outranks IR0 when rotate = 0
    irr = 8'h81; rot = 3'd0;
    do_ack("rot0", 1'b0, 1'b0);
    irr = 8'h00; rot = 3'd7;

    // In-service blocking
    isr = 8'h02; irr = 8'h04;
    step(); step();
    chk("isr_block.int", 32'(int_cpu), 32'd0);
    isr = 8'h04; irr = 8'h02;
    step(); step();
    chk("isr_pass.int", 32'(int_cpu), 32'd1);
    irr = 8'h00; isr = 8'h00;
    step();

    // Request dropped before INTA with auto EOI on -> spurious, no EOI
    irr = 8'h08; aeoi = 1'b1; vbase = 5'h03;
    do_ack("spurious", 1'b1, 1'b0);

    // Auto EOI on IR2 coinciding with specific EOI of level 5
    irr = 8'h04;
    do_ack("aeoi_cmd", 1'b0, 1'b1);
    irr = 8'h00; aeoi = 1'b0;

    // Non-specific EOI follows the in-service level
    isr = 8'h10; eoi_cmd = 1'b1; eoi_spec = 1'b0;
    step();
    eoi_cmd = 1'b0;
    chk("ns_eoi", 32'(eoi), 32'h10);
    isr = 8'h00; eoi_cmd = 1'b1;
    step();
    eoi_cmd = 1'b0;
    chk("ns_eoi_none", 32'(eoi), 32'h00);
    step();

    // Reset during WAIT2, then the next fall is a first pulse
    irr = 8'h10;
    step();
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    rst = 1'b1; step();
    chk("mid_rst.interrupt", 32'(intr), 32'd0);
    chk("mid_rst.int", 32'(int_cpu), 32'd0);
    chk("mid_rst.en", 32'(vec_en), 32'd0);
    chk("mid_rst.vector", 32'(vec_out), 32'd0);
    rst = 1'b0; step();
    chk("post_rst.int", 32'(int_cpu), 32'd1);
    inta_n = 1'b0; step();
    chk("post_rst.latch", 32'(latch), 32'd1);
    chk("post_rst.interrupt", 32'(intr), 32'h10);
    chk("post_rst.en", 32'(vec_en), 32'd0);
    exp_interrupt = 8'h10;
    inta_n = 1'b1; step();
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    step();
    irr = 8'h00;

    // Randomized handshakes against the priority model
    for (int i = 0; i < 24; i++) begin
      irr   = 8'($urandom);
      mask  = 8'($urandom);
      isr   = ($urandom_range(0, 3) == 0) ? 8'd0 : oh(int'($urandom_range(0, 7)));
      rot   = 3'($urandom);
      vbase = 5'($urandom);
      aeoi  = 1'($urandom);
      do_ack($sformatf("rand%0d", i), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
